// File: rtl/ufm_serial_reader.sv
// Serial read sequencer for the MAX 10 UFM: shifts a start address into the flash,
// then loads, serialises and streams DATA_W-bit words on a valid/ready port.
// Optional burst range check: define UFM_SERIAL_READER_RANGE_CHECK_EN.
module ufm_serial_reader #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 12,
  parameter int CLK_DIV  = 8,
  parameter int MAX_ADDR = 3071
) (
  input  logic              CLK100MHZ,
  input  logic              reset_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err,
  output logic              ufm_arclk,
  output logic              ufm_arshft,
  output logic              ufm_ardin,
  output logic              ufm_drclk,
  output logic              ufm_drshft,
  input  logic              ufm_drdout
);

  localparam int HALF     = CLK_DIV / 2;
  localparam int PH_W     = $clog2(CLK_DIV);
  localparam int BITS_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BIT_W    = $clog2(BITS_MAX);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(HALF);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  if (CLK_DIV < 4 || (CLK_DIV % 2) != 0 || MAX_ADDR < 0 || MAX_ADDR >= (1 << ADDR_W)) begin : g_param_check
    $error("ufm_serial_reader: CLK_DIV must be even and >= 4, MAX_ADDR must fit in ADDR_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SHIFT,
    HOLD,
    INC
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [ADDR_W-1:0]  addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0]  data_sr_q, data_sr_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               arclk_q, arclk_d;
  logic               arshft_q, arshft_d;
  logic               ardin_q, ardin_d;
  logic               drclk_q, drclk_d;
  logic               drshft_q, drshft_d;

  logic               req_ok;
  logic               period_end;
  logic [PH_W-1:0]    ph_step;

`ifdef UFM_SERIAL_READER_RANGE_CHECK_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic [SUM_W-1:0] end_addr;
  // One extra bit so addr + len can never wrap below MAX_ADDR.
  assign end_addr = SUM_W'(addr) + SUM_W'(len);
  assign req_ok   = (end_addr <= SUM_W'(MAX_ADDR));
`else
  assign req_ok   = 1'b1;
`endif

  assign period_end = (ph_q == PH_LAST);
  assign ph_step    = period_end ? '0 : ph_q + PH_W'(1);

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        if (req) begin
          if (req_ok) begin
            state_d   = ADDR;
            addr_sr_d = addr;
            cnt_d     = len;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ADDR: begin
        ph_d = ph_step;
        if (period_end) begin
          addr_sr_d = addr_sr_q << 1;
          if (bit_q == ADDR_LAST) begin
            bit_d   = '0;
            state_d = LOAD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      LOAD: begin
        ph_d = ph_step;
        if (period_end) begin
          bit_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        ph_d = ph_step;
        if (ph_q == PH_SAMPLE) begin
          data_sr_d = {data_sr_q[DATA_W-2:0], ufm_drdout};
        end
        // Last period has no drclk pulse; it only carries the final sample.
        if (period_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d      = '0;
            out_data_d = data_sr_q;
            state_d    = HOLD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      HOLD: begin
        ph_d = '0;
        if (out_ready) begin
          if (cnt_q == '0) begin
            out_data_d = '0;
            state_d    = IDLE;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = INC;
          end
        end
      end

      INC: begin
        ph_d = ph_step;
        if (period_end) begin
          state_d = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from next-state values so they line up with state_q
  // and shift/data lines only move on the first cycle of a low half.
  always_comb begin
    arclk_d  = ((state_d == ADDR) || (state_d == INC)) && (ph_d >= PH_HIGH);
    arshft_d = (state_d == ADDR);
    ardin_d  = (state_d == ADDR) && addr_sr_d[ADDR_W-1];
    drclk_d  = ((state_d == LOAD) || ((state_d == SHIFT) && (bit_d != DATA_LAST)))
               && (ph_d >= PH_HIGH);
    drshft_d = (state_d == SHIFT);
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      arclk_q    <= 1'b0;
      arshft_q   <= 1'b0;
      ardin_q    <= 1'b0;
      drclk_q    <= 1'b0;
      drshft_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      arclk_q    <= arclk_d;
      arshft_q   <= arshft_d;
      ardin_q    <= ardin_d;
      drclk_q    <= drclk_d;
      drshft_q   <= drshft_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == HOLD);
  assign out_data   = out_data_q;
  assign err        = err_q;
  assign ufm_arclk  = arclk_q;
  assign ufm_arshft = arshft_q;
  assign ufm_ardin  = ardin_q;
  assign ufm_drclk  = drclk_q;
  assign ufm_drshft = drshft_q;

endmodule

// File: tb/tb_ufm_serial_reader.sv
// Bench for ufm_serial_reader: behavioural UFM flash model, table-driven and
// randomized bursts, reset-abort and range-check sequences.
module tb_ufm_serial_reader;

  localparam int ADDR_W   = 23;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 12;
  localparam int CLK_DIV  = 8;
  localparam int MAX_ADDR = 3071;
  // Cycle of first out_valid, counting the req cycle as 0.
  localparam int FIRST_LAT = 1 + (ADDR_W + DATA_W) * CLK_DIV + CLK_DIV;
  // Non-valid cycles that follow a mid-burst handshake cycle.
  localparam int NEXT_LAT  = (2 + DATA_W - 1) * CLK_DIV + CLK_DIV;

  logic              CLK100MHZ = 1'b0;
  logic              reset_n   = 1'b0;
  logic              req       = 1'b0;
  logic [ADDR_W-1:0] addr      = '0;
  logic [LEN_W-1:0]  len       = '0;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              err;
  logic              ufm_arclk, ufm_arshft, ufm_ardin, ufm_drclk, ufm_drshft;
  logic              ufm_drdout;

  ufm_serial_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV), .MAX_ADDR(MAX_ADDR)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .req       (req),
    .addr      (addr),
    .len       (len),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err),
    .ufm_arclk (ufm_arclk),
    .ufm_arshft(ufm_arshft),
    .ufm_ardin (ufm_ardin),
    .ufm_drclk (ufm_drclk),
    .ufm_drshft(ufm_drshft),
    .ufm_drdout(ufm_drdout)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Flash contents: word 0 is a marker, otherwise n * 0x01010101.
  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] n);
    logic [63:0] p;
    p = 64'(n) * 64'h0101_0101;
    return (n == '0) ? 32'hDEAD_BEEF : p[DATA_W-1:0];
  endfunction

  // Behavioural flash: address register and data shift register.
  logic [ADDR_W-1:0] f_addr = '0;
  logic [DATA_W-1:0] f_data = '0;
  int ar_shift_rises = 0;
  int ar_inc_rises   = 0;

  always @(posedge ufm_arclk) begin
    if (ufm_arshft) begin
      f_addr         <= {f_addr[ADDR_W-2:0], ufm_ardin};
      ar_shift_rises <= ar_shift_rises + 1;
    end else begin
      f_addr       <= f_addr + ADDR_W'(1);
      ar_inc_rises <= ar_inc_rises + 1;
    end
  end

  always @(posedge ufm_drclk) begin
    if (!ufm_drshft) f_data <= word(f_addr);
    else             f_data <= f_data << 1;
  end

  assign ufm_drdout = f_data[DATA_W-1];

  // Shift/data lines may only move while both flash clocks are low.
  logic [2:0] prev_str = '0;
  int str_viol = 0;
  int err_seen = 0;
  always @(negedge CLK100MHZ) begin
    prev_str <= {ufm_arshft, ufm_ardin, ufm_drshft};
    if (reset_n && ({ufm_arshft, ufm_ardin, ufm_drshft} != prev_str) && (ufm_arclk || ufm_drclk))
      str_viol <= str_viol + 1;
    if (err) err_seen <= err_seen + 1;
  end

  int n_checks  = 0;
  int n_pass    = 0;
  int n_rejects = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_burst(input string tag, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                           input int stall_word, input int stall_cycles, input bit rnd_ready,
                           input bit poke, input logic [DATA_W-1:0] exp_first);
    int t, k, stalled, last_hs, limit, unstable, sh0, in0, busy_late;
    bit seen, accept;
    logic [DATA_W-1:0] held, exp_w;
    accept = 1'b1;
`ifdef UFM_SERIAL_READER_RANGE_CHECK_EN
    accept = (int'(a) + int'(l)) <= MAX_ADDR;
`endif
    sh0 = ar_shift_rises;
    in0 = ar_inc_rises;
    @(negedge CLK100MHZ);
    addr = a; len = l; req = 1'b1; out_ready = 1'b0;
    @(negedge CLK100MHZ);
    req = accept ? poke : 1'b0;
    if (!accept) begin
      n_rejects++;
      check({tag, "_err"}, 64'(err), 64'd1);
      check({tag, "_rej_busy"}, 64'(busy), 64'd0);
      @(negedge CLK100MHZ);
      check({tag, "_err_once"}, 64'(err), 64'd0);
      repeat (40) @(negedge CLK100MHZ);
      check({tag, "_rej_arclk"}, 64'(ar_shift_rises + ar_inc_rises - sh0 - in0), 64'd0);
      $display("burst %s addr=0x%0h len=%0d rejected", tag, a, l);
      return;
    end
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    t = 1; k = 0; stalled = 0; last_hs = 0; unstable = 0; seen = 1'b0; held = '0;
    limit = FIRST_LAT + (int'(l) + 1) * (NEXT_LAT + 1) + stall_cycles + 64;
    while (k <= int'(l) && t < limit) begin
      if (out_valid) begin
        if (!seen) begin
          seen  = 1'b1;
          held  = out_data;
          exp_w = (k == 0) ? exp_first : word(a + ADDR_W'(k));
          check($sformatf("%s_lat%0d", tag, k), 64'(t), 64'((k == 0) ? FIRST_LAT : last_hs + NEXT_LAT + 1));
          check($sformatf("%s_data%0d", tag, k), 64'(out_data), 64'(exp_w));
        end else if (out_data !== held) begin
          unstable++;
        end
        if (k == stall_word && stalled < stall_cycles) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          k++;
          last_hs = t;
          seen = 1'b0;
        end
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge CLK100MHZ);
      t++;
    end
    req = 1'b0;
    out_ready = 1'b0;
    check({tag, "_words"}, 64'(k), 64'(int'(l) + 1));
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    busy_late = 0;
    repeat (24) begin
      @(negedge CLK100MHZ);
      if (busy) busy_late++;
    end
    check({tag, "_stay_idle"}, 64'(busy_late), 64'd0);
    check({tag, "_stable"}, 64'(unstable), 64'd0);
    check({tag, "_addr_shifts"}, 64'(ar_shift_rises - sh0), 64'(ADDR_W));
    check({tag, "_incs"}, 64'(ar_inc_rises - in0), 64'(l));
    check({tag, "_flash_addr"}, 64'(f_addr), 64'(a + ADDR_W'(l)));
    $display("burst %s addr=0x%0h len=%0d words=%0d stalls=%0d", tag, a, l, k, stalled);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    int                stall_word;
    int                stall_cycles;
    bit                poke;
    logic [DATA_W-1:0] exp_first;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] ra;
    logic [LEN_W-1:0]  rl;

    vecs[0] = '{23'h000000, 12'd0, -1,  0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{23'h000005, 12'd3,  2, 50, 1'b0, 32'h0505_0505};
    vecs[2] = '{23'h2AAAAA, 12'd0, -1,  0, 1'b0, 32'h7F7F_54AA};
    vecs[3] = '{23'h000064, 12'd4, -1,  0, 1'b1, 32'h6464_6464};

    repeat (3) @(negedge CLK100MHZ);
    check("reset_outputs",
          64'({busy, out_valid, out_data, err, ufm_arclk, ufm_arshft, ufm_ardin, ufm_drclk, ufm_drshft}),
          64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    check("idle_outputs", 64'({busy, out_valid, out_data, err}), 64'd0);

    for (int i = 0; i < 4; i++) begin
      run_burst($sformatf("vec%0d", i), vecs[i].a, vecs[i].l, vecs[i].stall_word,
                vecs[i].stall_cycles, 1'b0, vecs[i].poke, vecs[i].exp_first);
    end

    // Reset abort during the SHIFT of the second word.
    @(negedge CLK100MHZ);
    addr = 23'd10; len = 12'd2; req = 1'b1;
    @(negedge CLK100MHZ);
    req = 1'b0;
    n = 0;
    while (!out_valid && n < 1000) begin @(negedge CLK100MHZ); n++; end
    check("abort_first_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge CLK100MHZ);
    out_ready = 1'b0;
    n = 0;
    while (!ufm_drshft && n < 1000) begin @(negedge CLK100MHZ); n++; end
    repeat (40) @(negedge CLK100MHZ);
    check("abort_in_shift", 64'(ufm_drshft), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs_zero",
          64'({busy, out_valid, out_data, err, ufm_arclk, ufm_arshft, ufm_ardin, ufm_drclk, ufm_drshft}),
          64'd0);
    repeat (3) @(negedge CLK100MHZ);
    reset_n = 1'b1;
    n = 0;
    repeat (600) begin
      @(negedge CLK100MHZ);
      if (out_valid || busy) n++;
    end
    check("abort_no_valid", 64'(n), 64'd0);
    $display("abort addr=0x%0h len=%0d reset during shift", 23'd10, 2);
    run_burst("after_abort", 23'd20, 12'd1, -1, 0, 1'b0, 1'b0, word(23'd20));

    // Range boundary: rejected only when the check is built in.
    run_burst("range_3070", 23'd3070, 12'd1, -1, 0, 1'b0, 1'b0, word(23'd3070));
    run_burst("range_3071", 23'd3071, 12'd1, -1, 0, 1'b0, 1'b0, word(23'd3071));

    for (int i = 0; i < 6; i++) begin
      ra = ADDR_W'($urandom_range(0, 3100));
      rl = LEN_W'($urandom_range(0, 3));
      run_burst($sformatf("rnd%0d", i), ra, rl, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 20)), 1'b1, 1'($urandom_range(0, 1)), word(ra));
    end

    repeat (4) @(negedge CLK100MHZ);
    check("strobe_low_half", 64'(str_viol), 64'd0);
    check("err_total", 64'(err_seen), 64'(n_rejects));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ufm_serial_reader.md
# ufm_serial_reader

Parametrised sequencer for the MAX 10 on-chip flash (UFM) serial read port. It accepts a start word address and burst length, and shifts the address into the flash block. It then loads and serialises each data word and presents it on a valid/ready stream. It sits between the flash block instance and the user logic of the top level, and replaces hand-driven `arclk`/`arshft`/`drclk`/`drshft` strobes.

## Interface
Parameters:
- `ADDR_W`, 23: flash address width; width of the `ardin` shift sequence.
- `DATA_W`, 32: flash word width.
- `LEN_W`, 12: burst length field width.
- `CLK_DIV`, 8: system cycles per flash clock period; even, ≥ 4. The default gives 12.5 MHz from 100 MHz.
- `MAX_ADDR`, 3071: highest valid UFM word address.

Ports:
- `CLK100MHZ` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: start pulse; sampled only when `busy`=0.
- `addr` in ADDR_W: first word address, captured with `req`.
- `len` in LEN_W: words minus one (0 = 1 word), captured with `req`.
- `busy` out 1: high from the cycle after an accepted `req` until the last word is handshaken.
- `out_valid` out 1: word available.
- `out_data` out DATA_W: word, MSB first as read from flash.
- `out_ready` in 1: consumer accept.
- `err` out 1: one-cycle pulse for a rejected request. See Configuration.
- `ufm_arclk`, `ufm_arshft`, `ufm_ardin` out 1 each: flash address port.
- `ufm_drclk`, `ufm_drshft` out 1 each: flash data port.
- `ufm_drdout` in 1: flash serial data.

## Operation
- Flash clock pulse: CLK_DIV cycles, consisting of a low half of CLK_DIV/2 cycles followed by a high half of CLK_DIV/2 cycles.
  - `arshft`, `ardin` and `drshft` change only on the first cycle of a low half.
  - `ufm_drdout` is sampled on the last cycle of a low half.
- State `IDLE`: all outputs are at reset values. An accepted `req` latches `addr` and `len` into internal registers, then goes to `ADDR`.
- State `ADDR`: ADDR_W pulses on `arclk` with `arshft`=1. `ardin` carries addr[ADDR_W-1] first, down to addr[0]. Then goes to `LOAD`.
- State `LOAD`: one `drclk` pulse with `drshft`=0, which moves the flash word into the shift register. Then goes to `SHIFT`.
- State `SHIFT`: DATA_W-1 `drclk` pulses with `drshft`=1.
  - Before each pulse, the sampled `drdout` is shifted into the LSB of the capture register.
  - One final sample is taken one full period after the last pulse.
  - The word is therefore DATA_W bits with the first bit at the MSB. Then goes to `HOLD`.
- State `HOLD`: `out_valid`=1 and `out_data` is stable until `out_valid && out_ready`.
  - On the handshake, if the remaining count is 0, go to `IDLE`.
  - Otherwise decrement the count and go to `INC`.
- State `INC`: one `arclk` pulse with `arshft`=0, which increments the flash address. Then goes to `LOAD`.
- Arithmetic: the remaining count is LEN_W bits and unsigned. The range check uses addr + len computed in ADDR_W+1 bits, so there is no overflow.
- Boundary conditions:
  - `req` while `busy` is ignored, with no `err`.
  - `req` in the same cycle as the final handshake is ignored, because `busy` is still 1 in that cycle.
  - `reset_n` deasserted mid-burst aborts immediately. Flash strobes drop to 0 asynchronously and no partial word is emitted.
  - `out_ready` held high yields back-to-back words with no extra stall cycles.

## Timing
- Reset values:
  - `busy`, `out_valid`, `err` = 0.
  - `out_data` = 0.
  - All `ufm_*` outputs = 0.
- Accepted `req` at cycle 0 raises `busy` at cycle 1.
- First `out_valid` at cycle 1 + (ADDR_W + DATA_W)·CLK_DIV + CLK_DIV = 449 with defaults.
- Next word: (2 + DATA_W - 1)·CLK_DIV + CLK_DIV = 272 cycles after the handshake cycle (defaults).
- `busy` falls in the cycle after the final handshake.

## Configuration
- Macro `UFM_SERIAL_READER_RANGE_CHECK_EN`.
- Defined: a `req` with addr + len > MAX_ADDR is rejected.
  - `err`=1 for one cycle, the cycle after `req`.
  - `busy` stays 0 and no flash strobes are generated.
- Undefined: no check is performed. `err` is tied 0, every request is accepted, and out-of-range words are whatever the flash returns.

## Test plan
- Single word: reset, `req` with addr=0, len=0, and a flash model holding 0xDEADBEEF.
  - `ardin` carries 23 zero bits with `arshft`=1.
  - `out_valid` is seen at cycle 449 with `out_data`=0xDEADBEEF.
  - `busy` is 0 after the handshake.
- Burst with backpressure: addr=5, len=3, model word n = n·0x01010101, `out_ready` low for 50 cycles on word 2.
  - Words 0x05050505…0x08080808 appear in order, with data stable while stalled.
  - Exactly 3 `arshft`=0 pulses occur.
- Address shift: addr=0x2AAAAA.
  - `ardin` toggles MSB-first with exactly 23 `arclk` rises while `arshft`=1.
  - All transitions fall in low halves.
- Ignored request: `req` asserted mid-burst, including in the final-handshake cycle.
  - No second burst starts.
  - Word count matches len+1.
- Reset abort: `reset_n` low during `SHIFT` of word 1.
  - All outputs read 0 in the same cycle.
  - No `out_valid`. A fresh `req` after release works normally.
- Range, with the macro defined: addr=3070, len=1 is accepted; addr=3071, len=1 gives an `err` pulse with no `arclk` activity. With the macro undefined, the latter is accepted and `err` stays 0.
